// File: rtl/logic_eval_pkg.sv
// logic_eval_pkg: shared state encoding and sweep sizing for logic_eval_sweep
package logic_eval_pkg;
  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_e;
  localparam int SWEEP_LEN = 32;
  localparam int CNT_W = 6;
endpackage

// File: rtl/logic_eval_core.sv
// logic_eval_core: per-lane f = (a&b) | ((c^d) & (INV_E ? ~e : e)), no cross-lane terms
module logic_eval_core #(
  parameter int W = 4,
  parameter bit INV_E = 1'b1
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  input  logic [W-1:0] d,
  input  logic [W-1:0] e,
  output logic [W-1:0] f
);
  assign f = (a & b) | ((c ^ d) & (INV_E ? ~e : e));
endmodule

// File: rtl/logic_eval_sweep.sv
// logic_eval_sweep: registered W-lane logic function with valid/ready handshake
// and a 32-combination scalar self-test sweep that counts true results.
module logic_eval_sweep
  import logic_eval_pkg::*;
#(
  parameter int W = 4,
  parameter bit INV_E = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [W-1:0]     c,
  input  logic [W-1:0]     d,
  input  logic [W-1:0]     e,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     z,
  input  logic             sweep_start,
  output logic             sweep_busy,
  output logic             sweep_done,
  output logic [CNT_W-1:0] ones_count
);
  state_e           state_q, state_d;
  logic [W-1:0]     z_q, z_d, f;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, ones_q, ones_d;
  logic             sweep_f, start, in_fire;
  logic_eval_core #(.W(W), .INV_E(INV_E)) u_data (
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f)
  );
  // Sweep operands come straight from the counter, a = MSB.
  logic_eval_core #(.W(1), .INV_E(INV_E)) u_sweep (
    .a(cnt_q[4]), .b(cnt_q[3]), .c(cnt_q[2]), .d(cnt_q[1]), .e(cnt_q[0]), .f(sweep_f)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      z_q         <= '0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
      ones_q      <= '0;
    end else begin
      state_q     <= state_d;
      z_q         <= z_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
      ones_q      <= ones_d;
    end
  end
  always_comb begin
    start   = (state_q == IDLE) && sweep_start && !out_valid_q;
    state_d = start ? SWEEP :
              (state_q == SWEEP && cnt_q == CNT_W'(SWEEP_LEN - 1)) ? DONE :
              (state_q == DONE) ? IDLE : state_q;
    cnt_d   = start ? '0 : (state_q == SWEEP) ? cnt_q + CNT_W'(1) : cnt_q;
    ones_d  = start ? '0 : (state_q == SWEEP) ? ones_q + CNT_W'(sweep_f) : ones_q;
  end
  always_comb begin
    in_ready    = (state_q == IDLE) && !sweep_start && (!out_valid_q || out_ready);
    sweep_busy  = (state_q == SWEEP);
    sweep_done  = (state_q == DONE);
    in_fire     = in_valid && in_ready;
    z_d         = in_fire ? f : z_q;
    out_valid_d = in_fire ? 1'b1 : (out_valid_q && out_ready) ? 1'b0 : out_valid_q;
  end
  assign z          = z_q;
  assign out_valid  = out_valid_q;
  assign ones_count = ones_q;
endmodule

// File: tb/tb_logic_eval_sweep.sv
// tb_logic_eval_sweep: vector table, handshake/sweep/reset sequences and random
// traffic against a lane-by-lane reference model, for INV_E=1 and INV_E=0.
module tb_logic_eval_sweep;
  logic clk = 0, rst_n = 0;
  logic in_valid = 0, out_ready = 1, sweep_start = 0;
  logic [3:0] a = 0, b = 0, c = 0, d = 0, e = 0;
  logic in_ready, out_valid, sweep_busy, sweep_done;
  logic [3:0] z;
  logic [5:0] ones_count;
  logic in_ready0, out_valid0, sweep_busy0, sweep_done0;
  logic [3:0] z0;
  logic [5:0] ones_count0;
  int n_cmp = 0, n_fail = 0;

  always #5 clk = ~clk;

  logic_eval_sweep #(.W(4), .INV_E(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c(c), .d(d), .e(e), .out_valid(out_valid), .out_ready(out_ready),
    .z(z), .sweep_start(sweep_start), .sweep_busy(sweep_busy), .sweep_done(sweep_done),
    .ones_count(ones_count)
  );
  logic_eval_sweep #(.W(4), .INV_E(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .a(a), .b(b), .c(c), .d(d), .e(e), .out_valid(out_valid0), .out_ready(out_ready),
    .z(z0), .sweep_start(sweep_start), .sweep_busy(sweep_busy0), .sweep_done(sweep_done0),
    .ones_count(ones_count0)
  );

  typedef struct packed {
    logic [3:0] a, b, c, d, e, z;
  } vec_t;
  vec_t tbl [9];

  function automatic logic [3:0] model(input logic [3:0] ma, mb, mc, md, me, input bit inv);
    logic [3:0] r;
    for (int i = 0; i < 4; i++)
      r[i] = (ma[i] && mb[i]) || ((mc[i] != md[i]) && (inv ? !me[i] : me[i]));
    return r;
  endfunction

  function automatic int sweep_ones(input bit inv);
    int n = 0;
    for (int k = 0; k < 32; k++) begin
      logic [4:0] v = 5'(k);
      if ((v[4] && v[3]) || ((v[2] != v[1]) && (inv ? !v[0] : v[0]))) n++;
    end
    return n;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic run_sweep(input bit poke, output int busy_n, output int done_n, output int done_at);
    busy_n = 0; done_n = 0; done_at = -1;
    sweep_start = 1;
    step;
    sweep_start = 0;
    for (int i = 0; i < 40; i++) begin
      if (poke && i == 5) sweep_start = 1;
      if (poke && i == 6) sweep_start = 0;
      if (i == 20) in_valid = 0;
      if (sweep_busy) busy_n++;
      if (sweep_done) begin done_n++; done_at = i; end
      if (i == 10) chk("sweep_in_ready", in_ready, 0);
      if (i == 25) chk("sweep_no_out_valid", out_valid, 0);
      step;
    end
  endtask

  initial begin
    int busy_n, done_n, done_at;
    logic [3:0] held, exp_z, exp_z0;
    bit exp_valid, rdy;
    tbl[0] = '{4'hF, 4'h3, 4'h5, 4'h0, 4'h4, 4'h3};
    tbl[1] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl[2] = '{4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'hF};
    tbl[3] = '{4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'hF};
    tbl[4] = '{4'h0, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0};
    tbl[5] = '{4'h0, 4'h0, 4'hA, 4'h5, 4'h3, 4'hC};
    tbl[6] = '{4'hC, 4'hA, 4'h0, 4'h0, 4'h0, 4'h8};
    tbl[7] = '{4'h0, 4'h0, 4'h3, 4'h3, 4'h0, 4'h0};
    tbl[8] = '{4'h1, 4'h1, 4'h6, 4'h0, 4'h1, 4'h7};

    #12;
    chk("rst_z", z, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", sweep_busy, 0);
    chk("rst_done", sweep_done, 0);
    chk("rst_ones", ones_count, 0);
    @(negedge clk) rst_n = 1;
    step;

    in_valid = 1; out_ready = 1;
    foreach (tbl[i]) begin
      {a, b, c, d, e} = {tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].d, tbl[i].e};
      #1 chk("tbl_in_ready", in_ready, 1);
      step;
      chk("tbl_z", z, tbl[i].z);
      chk("tbl_out_valid", out_valid, 1);
      chk("tbl_z_inv0", z0, model(a, b, c, d, e, 0));
    end

    out_ready = 0;
    {a, b, c, d, e} = {4'h9, 4'h9, 4'h1, 4'h2, 4'h0};
    held = z;
    for (int i = 0; i < 3; i++) begin
      step;
      chk("bp_z_stable", z, held);
      chk("bp_valid_stable", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
    end
    out_ready = 1;
    #1 chk("bp_release_ready", in_ready, 1);
    step;
    chk("bp_next_z", z, model(4'h9, 4'h9, 4'h1, 4'h2, 4'h0, 1));
    chk("bp_next_valid", out_valid, 1);
    in_valid = 0;
    step;
    chk("bp_drain", out_valid, 0);

    in_valid = 1;
    sweep_start = 1;
    #1 chk("sweep_priority", in_ready, 0);
    run_sweep(1, busy_n, done_n, done_at);
    chk("sweep_busy_cycles", busy_n, 32);
    chk("sweep_done_pulses", done_n, 1);
    chk("sweep_done_at", done_at, 32);
    chk("sweep_ones", ones_count, 14);
    chk("sweep_ones_model", ones_count, sweep_ones(1));
    chk("sweep_ones_inv0", ones_count0, sweep_ones(0));

    in_valid = 1; out_ready = 0;
    {a, b, c, d, e} = {4'h6, 4'h6, 4'h0, 4'h0, 4'h0};
    step;
    in_valid = 0;
    sweep_start = 1;
    step;
    sweep_start = 0;
    chk("ign_busy", sweep_busy, 0);
    chk("ign_ones", ones_count, 14);
    chk("ign_z", z, 4'h6);
    step;
    chk("ign_busy2", sweep_busy, 0);
    out_ready = 1;
    step;
    chk("ign_drain", out_valid, 0);

    sweep_start = 1;
    step;
    sweep_start = 0;
    repeat (10) step;
    #2 rst_n = 0;
    #1;
    chk("mrst_busy", sweep_busy, 0);
    chk("mrst_done", sweep_done, 0);
    chk("mrst_ones", ones_count, 0);
    chk("mrst_z", z, 0);
    chk("mrst_valid", out_valid, 0);
    @(negedge clk) rst_n = 1;
    busy_n = 0; done_n = 0;
    for (int i = 0; i < 40; i++) begin
      if (sweep_busy) busy_n++;
      if (sweep_done) done_n++;
      step;
    end
    chk("mrst_no_busy", busy_n, 0);
    chk("mrst_no_done", done_n, 0);
    run_sweep(0, busy_n, done_n, done_at);
    chk("resweep_ones", ones_count, 14);
    chk("resweep_done", done_n, 1);
    chk("resweep_ones_inv0", ones_count0, 14);

    exp_valid = 0;
    for (int k = 0; k < 300; k++) begin
      in_valid = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      a = 4'($urandom); b = 4'($urandom); c = 4'($urandom); d = 4'($urandom); e = 4'($urandom);
      #1;
      rdy = !exp_valid || out_ready;
      chk("rnd_in_ready", in_ready, rdy);
      if (in_valid && rdy) begin
        exp_valid = 1;
        exp_z = model(a, b, c, d, e, 1);
        exp_z0 = model(a, b, c, d, e, 0);
      end else if (out_ready) exp_valid = 0;
      step;
      chk("rnd_out_valid", out_valid, exp_valid);
      if (exp_valid) begin
        chk("rnd_z", z, exp_z);
        chk("rnd_z_inv0", z0, exp_z0);
      end
    end

    in_valid = 1; out_ready = 1;
    for (int k = 0; k < 32; k++) begin
      for (int i = 0; i < 4; i++) begin
        logic [4:0] v = 5'((k + i * 7) % 32);
        {a[i], b[i], c[i], d[i], e[i]} = v;
      end
      step;
      chk("exh_z", z, model(a, b, c, d, e, 1));
      chk("exh_z_inv0", z0, model(a, b, c, d, e, 0));
    end
    in_valid = 0;
    step;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
